daq_drain: RTL and testbench

- Sequencer on the read side of the DAQ ring buffer.
- Pops packet lengths from the DAQ length FIFO and reads the matching payload words from the data port.
- Coalesces one or more DAQ packets into a MAC frame with a frame header, a timestamp and per-packet sub-headers.
- Streams the frame to the MAC TX path over a valid/ready interface.

---
 rtl/daq_pkg.sv | 21 ++
 rtl/daq_drain_if.sv | 18 +
 rtl/daq_drain_skid.sv | 82 ++++++++
 rtl/daq_drain.sv | 209 ++++++++++++++++++++
 tb/tb_daq_drain.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/daq_pkg.sv
// daq_pkg: shared constants for the DAQ drain sequencer.
//   - Header tag bytes placed in the top byte of frame words.
//   - State encoding of the drain sequencer FSM.
package daq_pkg;

    localparam logic [7:0] TAG_FRAME   = 8'hDA;  // frame header W0
    localparam logic [7:0] TAG_SUB     = 8'hD1;  // per-packet sub-header
    localparam logic [7:0] TAG_TRAILER = 8'hDF;  // optional frame trailer
    localparam logic [7:0] TAG_DISCARD = 8'hFE;  // discard marker inside payload (passed verbatim)

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        SUB,
        PAYLOAD,
        NEXT,
        TRAIL
    } state_t;

endpackage

// File: rtl/daq_drain_if.sv
// daq_drain_if: valid/ready word stream towards the MAC TX path.
//   tx_data  : 32-bit frame word
//   tx_valid : tx_data valid
//   tx_last  : final word of frame (qualified by tx_valid)
//   tx_ready : sink accepts the word when tx_valid && tx_ready
// master = frame source (daq_drain), slave = MAC TX sink.
interface daq_drain_if;
    import daq_pkg::*;

    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/daq_drain_skid.sv
// daq_drain_skid: 2-entry 32-bit valid/ready buffer with a last flag.
// Each entry also carries a hold flag: a held entry is not presented while
// it is the only word buffered, so the sequencer can delay a frame's final
// word until it knows whether the frame closes. 'close' marks the youngest
// entry as last and releases it.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid, in_data,          push one word (caller guarantees space:
//   in_last, in_hold            count < 2, or a pop in the same cycle)
//   close                       set last and clear hold on youngest entry
//   out_data, out_valid,        head of buffer towards the sink
//   out_last, out_ready
//   count                       number of buffered words
module daq_drain_skid
    import daq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_hold,
    input  logic        close,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [1:0]  count
);

    logic [31:0] data_reg [2];
    logic        last_reg [2];
    logic        hold_reg [2];
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  count_reg;
    logic        pop;
    logic        youngest;

    // A held word only blocks when alone; with a word behind it, it is no
    // longer the frame's final word and may go.
    assign out_valid = (count_reg == 2'd2) ||
                       ((count_reg == 2'd1) && !hold_reg[rd_ptr_reg]);
    assign out_data  = data_reg[rd_ptr_reg];
    assign out_last  = last_reg[rd_ptr_reg];
    assign pop       = out_valid && out_ready;
    assign youngest  = ~wr_ptr_reg;
    assign count     = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg[gi] <= '0;
                    last_reg[gi] <= 1'b0;
                    hold_reg[gi] <= 1'b0;
                end else if (in_valid && (wr_ptr_reg == 1'(gi))) begin
                    data_reg[gi] <= in_data;
                    last_reg[gi] <= in_last;
                    hold_reg[gi] <= in_hold;
                end else if (close && (youngest == 1'(gi))) begin
                    last_reg[gi] <= 1'b1;
                    hold_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (in_valid) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)      rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(in_valid) - 2'(pop);
        end
    end

endmodule

// File: rtl/daq_drain.sv
// daq_drain: read-side sequencer of the DAQ ring buffer. Pops packet lengths,
// reads payload words and coalesces packets into MAC frames:
//   W0 {DA, seq, 0000}, W1 systime, then per packet {D1, 0, len} + payload.
// Optional macro DAQ_DRAIN_TRAILER_EN appends {DF, npkts, xsum} carrying
// tx_last; otherwise the final payload/sub-header word is held back and
// released with tx_last when the frame closes.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   systime              free-running time, sampled when a frame opens
//   len_in, len_ready    head of DAQ length FIFO / FIFO non-empty
//   len_rd_en            one-cycle pop pulse to the length FIFO
//   data_in, data_rd_en  DAQ ring data (one cycle after data_rd_en) / read
//   tx                   daq_drain_if master: tx_data/valid/last/ready
module daq_drain
    import daq_pkg::*;
#(
    parameter int MAC_PACKET_BITS = 11,
    parameter int MAX_WORDS       = 360,
    parameter int FLUSH_CYCLES    = 1000,
    parameter int FLUSH_BITS      = $clog2(FLUSH_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                systime,
    input  logic [MAC_PACKET_BITS-1:0] len_in,
    input  logic                       len_ready,
    output logic                       len_rd_en,
    input  logic [31:0]                data_in,
    output logic                       data_rd_en,
    daq_drain_if.master                tx
);

    localparam int WU_BITS = $clog2(MAX_WORDS + 1);
`ifdef DAQ_DRAIN_TRAILER_EN
    localparam int   TRAILER_WORDS = 1;
    localparam logic HOLD_TAIL     = 1'b0;
`else
    localparam int   TRAILER_WORDS = 0;
    localparam logic HOLD_TAIL     = 1'b1;
`endif

    state_t                     state_reg;
    logic [7:0]                 seq_reg;
    logic [MAC_PACKET_BITS-1:0] len_reg;
    logic [MAC_PACKET_BITS-1:0] rd_left_reg;
    logic [31:0]                ts_reg;
    logic [WU_BITS-1:0]         words_used_reg;
    logic [FLUSH_BITS-1:0]      flush_cnt_reg;
    logic                       rd_pending_reg;
    logic                       data_rd_en_reg;
    logic                       len_rd_en_reg;
`ifdef DAQ_DRAIN_TRAILER_EN
    logic [7:0]                 npkts_reg;
    logic [15:0]                xsum_reg;
`endif

    logic        push, push_last, push_hold, close;
    logic [31:0] push_data;
    logic [1:0]  skid_count;
    logic [2:0]  occupancy;
    logic        pop, skid_space, fits, close_now, rd_issue, payload_tail;

    assign pop        = tx.tx_valid && tx.tx_ready;
    assign skid_space = (skid_count != 2'd2) || pop;
    assign fits       = (32'(words_used_reg) + 32'(len_in) + 32'(1 + TRAILER_WORDS))
                        <= 32'(MAX_WORDS);
    assign close_now  = !(len_ready && fits) &&
                        (len_ready || (flush_cnt_reg == FLUSH_BITS'(FLUSH_CYCLES)));

    // Reads land one cycle after data_rd_en, and data_rd_en itself is
    // registered, so up to two words are in flight. Only issue a read if the
    // skid can still hold every in-flight word plus this one.
    assign occupancy    = 3'(skid_count) + 3'(rd_pending_reg) + 3'(data_rd_en_reg) - 3'(pop);
    assign rd_issue     = (state_reg == PAYLOAD) && (rd_left_reg != '0) && (occupancy <= 3'd1);
    assign payload_tail = (rd_left_reg == '0) && !data_rd_en_reg;

    assign len_rd_en  = len_rd_en_reg;
    assign data_rd_en = data_rd_en_reg;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        push_last = 1'b0;
        push_hold = 1'b0;
        close     = 1'b0;
        case (state_reg)
            HDR0: begin
                push      = skid_space;
                push_data = {TAG_FRAME, seq_reg, 16'h0000};
            end
            HDR1: begin
                push      = skid_space;
                push_data = ts_reg;
            end
            SUB: begin
                push      = skid_space;
                push_data = {TAG_SUB, 24'(len_reg)};
                push_hold = HOLD_TAIL && (len_reg == '0);
            end
            PAYLOAD: begin
                push      = rd_pending_reg;
                push_data = data_in;
                push_hold = HOLD_TAIL && payload_tail;
            end
            NEXT: close = HOLD_TAIL && close_now;
`ifdef DAQ_DRAIN_TRAILER_EN
            TRAIL: begin
                push      = skid_space;
                push_data = {TAG_TRAILER, npkts_reg, xsum_reg};
                push_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            seq_reg        <= '0;
            len_reg        <= '0;
            rd_left_reg    <= '0;
            ts_reg         <= '0;
            words_used_reg <= '0;
            flush_cnt_reg  <= '0;
            rd_pending_reg <= 1'b0;
            data_rd_en_reg <= 1'b0;
            len_rd_en_reg  <= 1'b0;
`ifdef DAQ_DRAIN_TRAILER_EN
            npkts_reg      <= '0;
            xsum_reg       <= '0;
`endif
        end else begin
            len_rd_en_reg  <= 1'b0;
            data_rd_en_reg <= rd_issue;
            rd_pending_reg <= data_rd_en_reg;
            if (push)     words_used_reg <= words_used_reg + WU_BITS'(1);
            if (rd_issue) rd_left_reg    <= rd_left_reg - MAC_PACKET_BITS'(1);
            case (state_reg)
                IDLE: if (len_ready) begin
                    len_rd_en_reg  <= 1'b1;
                    len_reg        <= len_in;
                    ts_reg         <= systime;
                    words_used_reg <= '0;
                    flush_cnt_reg  <= '0;
`ifdef DAQ_DRAIN_TRAILER_EN
                    npkts_reg      <= 8'd1;
                    xsum_reg       <= '0;
`endif
                    state_reg      <= HDR0;
                end
                HDR0: if (push) state_reg <= HDR1;
                HDR1: if (push) state_reg <= SUB;
                SUB: if (push) begin
                    rd_left_reg <= len_reg;
                    state_reg   <= (len_reg == '0) ? NEXT : PAYLOAD;
                end
                PAYLOAD: if (push) begin
`ifdef DAQ_DRAIN_TRAILER_EN
                    xsum_reg <= xsum_reg ^ data_in[31:16] ^ data_in[15:0];
`endif
                    if (payload_tail) state_reg <= NEXT;
                end
                NEXT: begin
                    if (len_ready && fits) begin
                        len_rd_en_reg <= 1'b1;
                        len_reg       <= len_in;
                        flush_cnt_reg <= '0;
`ifdef DAQ_DRAIN_TRAILER_EN
                        npkts_reg     <= npkts_reg + 8'd1;
`endif
                        state_reg     <= SUB;
                    end else if (close_now) begin
                        flush_cnt_reg <= '0;
`ifdef DAQ_DRAIN_TRAILER_EN
                        state_reg     <= TRAIL;
`else
                        seq_reg       <= seq_reg + 8'd1;
                        state_reg     <= IDLE;
`endif
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + FLUSH_BITS'(1);
                    end
                end
                TRAIL: if (push) begin
                    seq_reg   <= seq_reg + 8'd1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    daq_drain_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   (push_data),
        .in_last   (push_last),
        .in_hold   (push_hold),
        .close     (close),
        .out_data  (tx.tx_data),
        .out_valid (tx.tx_valid),
        .out_last  (tx.tx_last),
        .out_ready (tx.tx_ready),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_daq_drain.sv
// tb_daq_drain: directed, table-driven bench for daq_drain.
// Models the length FIFO and the DAQ ring (1-cycle read latency), records
// every accepted tx word and compares the stream against hand-built frames.
module tb_daq_drain;

    localparam int MPB   = 11;
    localparam int MAXW  = 12;
    localparam int FLUSH = 16;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        logic [31:0] ts;
        int          len0;
        int          len1;       // -1: no second packet
        int          gap;        // cycles between the two length pushes
        bit          toggle;     // tx_ready toggles every cycle
        int          frames;     // frames expected from this scenario
        int          rd_expect;  // data_rd_en pulses expected
    } scen_t;

    logic           clk;
    logic           rst;
    logic [31:0]    systime;
    logic [MPB-1:0] len_in;
    logic           len_ready;
    logic           len_rd_en;
    logic [31:0]    data_in;
    logic           data_rd_en;
    daq_drain_if    tx_if ();

    daq_drain #(
        .MAC_PACKET_BITS (MPB),
        .MAX_WORDS       (MAXW),
        .FLUSH_CYCLES    (FLUSH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .systime    (systime),
        .len_in     (len_in),
        .len_ready  (len_ready),
        .len_rd_en  (len_rd_en),
        .data_in    (data_in),
        .data_rd_en (data_rd_en),
        .tx         (tx_if)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    len_q[$];
    word_t got_q[$];
    word_t exp_q[$];
    int    data_ptr    = 0;
    int    rd_cnt      = 0;
    int    frames_done = 0;
    bit    toggle      = 0;
    scen_t scen[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ring_word(input int i);
        logic [31:0] w;
        w = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
        if (i % 4 == 2) w[31:24] = 8'hFE;   // discard marker, passed verbatim
        return w;
    endfunction

    task automatic add_word(input logic [31:0] d, input logic l);
        word_t w;
        w.data = d;
        w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic add_frame(input int seq, input logic [31:0] ts, input int start,
                             input int l0, input int l1);
        int lens[2];
        int np;
        int idx;
        logic [31:0] w;
`ifdef DAQ_DRAIN_TRAILER_EN
        logic [15:0] xs = '0;
`endif
        lens[0] = l0;
        lens[1] = l1;
        np  = (l1 >= 0) ? 2 : 1;
        idx = start;
        add_word({8'hDA, 8'(seq), 16'h0000}, 1'b0);
        add_word(ts, 1'b0);
        for (int p = 0; p < np; p++) begin
            add_word({8'hD1, 24'(lens[p])}, 1'b0);
            for (int k = 0; k < lens[p]; k++) begin
                w = ring_word(idx);
                idx++;
`ifdef DAQ_DRAIN_TRAILER_EN
                xs = xs ^ w[31:16] ^ w[15:0];
`endif
                add_word(w, 1'b0);
            end
        end
`ifdef DAQ_DRAIN_TRAILER_EN
        add_word({8'hDF, 8'(np), xs}, 1'b1);
`else
        exp_q[exp_q.size() - 1].last = 1'b1;
`endif
    endtask

    // Upstream model: length FIFO pop and ring read act on the clock edge,
    // new values are driven 1 ns later. Upstream is reset with the DUT.
    initial begin
        bit pop_now, rd_now, rst_now;
        len_ready = 1'b0;
        len_in    = '0;
        data_in   = '0;
        forever begin
            @(posedge clk);
            pop_now = len_rd_en;
            rd_now  = data_rd_en;
            rst_now = rst;
            #1;
            if (rst_now) begin
                data_ptr = 0;
                len_q.delete();
            end else begin
                if (pop_now && len_q.size() > 0) void'(len_q.pop_front());
                if (rd_now) begin
                    data_in = ring_word(data_ptr);
                    data_ptr++;
                    rd_cnt++;
                end
            end
            len_ready = (len_q.size() != 0);
            len_in    = len_ready ? MPB'(len_q[0]) : '0;
        end
    end

    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_if.tx_ready = toggle ? ~tx_if.tx_ready : 1'b1;
        end
    end

    // Monitor: record accepted words; a stalled word must stay unchanged.
    initial begin
        word_t w;
        bit          stall_prev = 0;
        logic [31:0] prev_data  = '0;
        logic        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(tx_if.tx_valid), 64'(1));
                    check("stall_data", 64'(tx_if.tx_data), 64'(prev_data));
                    check("stall_last", 64'(tx_if.tx_last), 64'(prev_last));
                end
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    w.data = tx_if.tx_data;
                    w.last = tx_if.tx_last;
                    got_q.push_back(w);
                    if (tx_if.tx_last) frames_done++;
                end
                stall_prev = tx_if.tx_valid && !tx_if.tx_ready;
                prev_data  = tx_if.tx_data;
                prev_last  = tx_if.tx_last;
            end
        end
    end

    task automatic wait_frames(input int target, input string name);
        int cyc = 0;
        while (frames_done < target && cyc < 600) begin
            @(posedge clk);
            cyc++;
        end
        if (frames_done < target)
            check({name, "_timeout"}, 64'(frames_done), 64'(target));
    endtask

    task automatic push_len(input int l);
        @(posedge clk);
        #2;
        len_q.push_back(l);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_tx_valid"}, 64'(tx_if.tx_valid), 64'(0));
        check({tag, "_tx_last"}, 64'(tx_if.tx_last), 64'(0));
        check({tag, "_tx_data"}, 64'(tx_if.tx_data), 64'(0));
        check({tag, "_len_rd_en"}, 64'(len_rd_en), 64'(0));
        check({tag, "_data_rd_en"}, 64'(data_rd_en), 64'(0));
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_w%0d_data", tag, i), 64'(got_q[i].data), 64'(exp_q[i].data));
                check($sformatf("%s_w%0d_last", tag, i), 64'(got_q[i].last), 64'(exp_q[i].last));
            end
        end
    endtask

    initial begin
        int target;
        int rd0;
        int cyc;

        // Scenario table: {ts, len0, len1, gap, toggle, frames, rd_expect}
        scen[0] = '{32'h0000_1000, 3, -1, 0, 1'b0, 1, 3};  // single packet, flush close
        scen[1] = '{32'h0000_2000, 2,  1, 5, 1'b0, 1, 3};  // coalesced pair
        scen[2] = '{32'h0000_3000, 4,  5, 0, 1'b0, 2, 9};  // 2nd packet does not fit
        scen[3] = '{32'h0000_4000, 8, -1, 0, 1'b1, 1, 8};  // ready toggling
        scen[4] = '{32'h0000_5000, 0, -1, 0, 1'b0, 1, 0};  // zero-length packet

        // Expected word stream (ring indices run on across scenarios).
        add_frame(0, 32'h0000_1000, 0, 3, -1);
        add_frame(1, 32'h0000_2000, 3, 2, 1);
        add_frame(2, 32'h0000_3000, 6, 4, -1);
        add_frame(3, 32'h0000_3000, 10, 5, -1);
        add_frame(4, 32'h0000_4000, 15, 8, -1);
        add_frame(5, 32'h0000_5000, 23, 0, -1);

        rst     = 1'b1;
        systime = '0;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int s = 0; s < 5; s++) begin
            systime = scen[s].ts;
            toggle  = scen[s].toggle;
            target  = frames_done + scen[s].frames;
            rd0     = rd_cnt;
            push_len(scen[s].len0);
            if (scen[s].len1 >= 0) begin
                repeat (scen[s].gap) @(posedge clk);
                push_len(scen[s].len1);
            end
            wait_frames(target, $sformatf("scen%0d", s));
            toggle = 1'b0;
            repeat (4) @(posedge clk);
            check($sformatf("scen%0d_rd_count", s), 64'(rd_cnt - rd0), 64'(scen[s].rd_expect));
            $display("scenario %0d: len0=%0d len1=%0d frames=%0d reads=%0d",
                     s, scen[s].len0, scen[s].len1, frames_done, rd_cnt - rd0);
        end
        compare_stream("stream");

        // Reset in the middle of a payload: frame abandoned without tx_last.
        got_q.delete();
        exp_q.delete();
        systime = 32'h0000_6000;
        push_len(6);
        cyc = 0;
        while (got_q.size() < 5 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        check("midrst_reach_payload", 64'(got_q.size() >= 5), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        check_reset_outputs("midrst");
        for (int i = 0; i < got_q.size(); i++)
            check($sformatf("midrst_w%0d_no_last", i), 64'(got_q[i].last), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("mid-payload reset: %0d words of abandoned frame seen", got_q.size());
        got_q.delete();

        // First frame after reset restarts at seq 0 and ring index 0.
        systime = 32'h0000_7000;
        add_frame(0, 32'h0000_7000, 0, 1, -1);
        target = frames_done + 1;
        push_len(1);
        wait_frames(target, "postrst");
        repeat (4) @(posedge clk);
        compare_stream("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
